boot_loader_ctrl: RTL

Boot sequencer for the rv32i single-core datapath. It accepts a word stream over a valid/ready port. It writes a data image into the data BRAM and a program image into the instruction BRAM, using word-aligned byte addresses. It then pulses the core reset and releases the core to execute. It owns every load-time control that is otherwise hand-driven: BRAM write ports, data-BRAM mux select, `pc_stall`, `i_r_enb` and `rd_enbl`.

---
 rtl/boot_loader_ctrl_pkg.sv | 22 ++
 rtl/boot_loader_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared constants for the rv32i boot loader: default geometry, FSM state
// encodings and the word-to-byte address shift.
package boot_loader_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_I_DEPTH    = 256;
  localparam int unsigned DEF_D_DEPTH    = 256;

  // BRAM addresses are byte addresses of 32-bit words
  localparam int unsigned WORD_SHIFT = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_D  = 3'd1;
  localparam logic [2:0] ST_HDR_I  = 3'd2;
  localparam logic [2:0] ST_LOAD_D = 3'd3;
  localparam logic [2:0] ST_LOAD_I = 3'd4;
  localparam logic [2:0] ST_START  = 3'd5;
  localparam logic [2:0] ST_RUN    = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

endpackage

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: streams a data image and a program image into the BRAMs,
// pulses the core reset once, then releases the core to run.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned I_DEPTH    = DEF_I_DEPTH,
  parameter int unsigned D_DEPTH    = DEF_D_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  restart,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  core_rst,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  running,
  output logic                  error
);

  // Counters are one bit wider than the depth index so a full-depth count fits
  localparam int unsigned D_CNT_W = $clog2(D_DEPTH) + 1;
  localparam int unsigned I_CNT_W = $clog2(I_DEPTH) + 1;
  localparam int unsigned CNT_W   = (D_CNT_W > I_CNT_W) ? D_CNT_W : I_CNT_W;

  localparam logic [DATA_WIDTH-1:0] D_MAX = DATA_WIDTH'(D_DEPTH);
  localparam logic [DATA_WIDTH-1:0] I_MAX = DATA_WIDTH'(I_DEPTH);

  logic [2:0]       state, next_state;
  logic [CNT_W-1:0] word_cnt, nd, ni;
  logic             hs, d_last, i_last;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] k);
    logic [CNT_W+WORD_SHIFT-1:0] byte_addr;
    byte_addr = {k, {WORD_SHIFT{1'b0}}};
    return ADDR_WIDTH'(byte_addr);
  endfunction

  assign hs     = s_valid && s_ready;
  assign d_last = (word_cnt == nd - CNT_W'(1));
  assign i_last = (word_cnt == ni - CNT_W'(1));

  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) next_state = ST_HDR_D;
        ST_HDR_D:  if (hs) next_state = (s_data > D_MAX) ? ST_ERR : ST_HDR_I;
        ST_HDR_I: begin
          if (hs) begin
            if (s_data == '0 || s_data > I_MAX) next_state = ST_ERR;
            else if (nd == '0)                  next_state = ST_LOAD_I;
            else                                next_state = ST_LOAD_D;
          end
        end
        ST_LOAD_D: if (hs && d_last) next_state = ST_LOAD_I;
        ST_LOAD_I: if (hs && i_last) next_state = ST_START;
        ST_START:  next_state = ST_RUN;
        default:   next_state = state;
      endcase
    end
  end

  // Control outputs are registered decodes of the next state, so they line up with state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      word_cnt         <= '0;
      nd               <= '0;
      ni               <= '0;
      s_ready          <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      d_bram_init_done <= 1'b0;
      core_rst         <= 1'b0;
      pc_stall         <= 1'b1;
      i_r_enb          <= 1'b0;
      rd_enbl          <= 1'b0;
      running          <= 1'b0;
      error            <= 1'b0;
    end else begin
      state            <= next_state;
      i_w_enb          <= 1'b0;
      d_w_enb          <= 1'b0;
      s_ready          <= (next_state == ST_HDR_D)  || (next_state == ST_HDR_I) ||
                          (next_state == ST_LOAD_D) || (next_state == ST_LOAD_I);
      core_rst         <= (next_state == ST_START);
      d_bram_init_done <= (next_state == ST_START) || (next_state == ST_RUN);
      pc_stall         <= (next_state != ST_RUN);
      i_r_enb          <= (next_state == ST_RUN);
      rd_enbl          <= (next_state == ST_RUN);
      running          <= (next_state == ST_RUN);
      error            <= (next_state == ST_ERR);

      if (restart) begin
        word_cnt <= '0;
        nd       <= '0;
        ni       <= '0;
      end else begin
        case (state)
          ST_IDLE:  word_cnt <= '0;
          ST_HDR_D: if (hs) nd <= CNT_W'(s_data);
          ST_HDR_I: begin
            if (hs) begin
              ni       <= CNT_W'(s_data);
              word_cnt <= '0;
            end
          end
          ST_LOAD_D: begin
            if (hs) begin
              d_w_enb  <= 1'b1;
              d_w_addr <= word_addr(word_cnt);
              d_w_dat  <= s_data;
              word_cnt <= d_last ? '0 : word_cnt + CNT_W'(1);
            end
          end
          ST_LOAD_I: begin
            if (hs) begin
              i_w_enb  <= 1'b1;
              i_w_addr <= word_addr(word_cnt);
              i_w_dat  <= s_data;
              word_cnt <= i_last ? '0 : word_cnt + CNT_W'(1);
            end
          end
          default: word_cnt <= word_cnt;
        endcase
      end
    end
  end

endmodule
